// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit, state and packet-entry definitions for the packet injector
//
// Contents:
//   flit_type_e   : flit type encodings as they appear on flit_type
//   inj_state_e   : injector control states
//   pkt_entry_t   : one packet table entry (fields sized for the largest supported configuration)
//   flit_type_for : maps first/last flit position to a flit type
package noc_pkg;

    // Entry fields are sized for the largest configuration; the injector
    // zero-extends on write and uses only its own low-order bits on read.
    localparam int ENTRY_DEST_W = 16;
    localparam int ENTRY_VC_W   = 8;
    localparam int ENTRY_LEN_W  = 16;

    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_HEAD      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } inj_state_e;

    typedef struct packed {
        logic [ENTRY_DEST_W-1:0] dest;
        logic [ENTRY_VC_W-1:0]   vc;
        logic [ENTRY_LEN_W-1:0]  len;
    } pkt_entry_t;

    function automatic flit_type_e flit_type_for(input logic first, input logic last);
        if (first && last) begin
            return FLIT_HEAD_TAIL;
        end
        if (first) begin
            return FLIT_HEAD;
        end
        if (last) begin
            return FLIT_TAIL;
        end
        return FLIT_BODY;
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// rtl/vc_credit_counter.sv - credit counter for one virtual channel of the injection port
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset (count returns to VCS_SIZE)
//   send      : a flit is sent on this VC this cycle (only asserted when nonzero)
//   ret       : one credit is returned on this VC this cycle
//   nonzero   : at least one credit is available
//   overflow  : a return arrived while already full with no send; count saturates
module vc_credit_counter
    import noc_pkg::*;
#(
    parameter int VCS_SIZE = 4,
    parameter int CNT_W    = $clog2(VCS_SIZE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic send,
    input  logic ret,
    output logic nonzero,
    output logic overflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(VCS_SIZE);

    logic [CNT_W-1:0] count;

    assign nonzero  = (count != '0);
    // A simultaneous send absorbs the return, so only a lone return can overflow.
    assign overflow = ret && !send && (count == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= FULL;
        end else begin
            case ({send, ret})
                2'b10: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                2'b01: begin
                    if (count != FULL) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/packet_injector.sv
// rtl/packet_injector.sv - table-driven packet injector with per-VC credit flow control
//
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   cfg_we/idx/dest/vc/len    : packet table write (accepted in IDLE and DONE only)
//   cfg_num_packets           : number of table entries to inject, latched on start
//   start                     : begin injection when IDLE
//   flit_valid/type/vc/dest/seq : registered flit output, held while flit_valid=0
//   credit_valid, credit_vc   : one returned credit per cycle
//   busy, done, credit_err    : status (done and credit_err are sticky until rst)
module packet_injector
    import noc_pkg::*;
#(
    parameter int NUM_VCS        = 2,
    parameter int VCS_SIZE       = 4,
    parameter int MAX_PACKETS    = 64,
    parameter int NUM_OF_ROUTERS = 16,
    parameter int LEN_W          = 8,
    localparam int IDX_W         = $clog2(MAX_PACKETS),
    localparam int DEST_W        = $clog2(NUM_OF_ROUTERS),
    localparam int VC_W          = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DEST_W-1:0] cfg_dest,
    input  logic [VC_W-1:0]   cfg_vc,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [IDX_W:0]    cfg_num_packets,
    input  logic              start,
    output logic              flit_valid,
    output logic [1:0]        flit_type,
    output logic [VC_W-1:0]   flit_vc,
    output logic [DEST_W-1:0] flit_dest,
    output logic [LEN_W-1:0]  flit_seq,
    input  logic              credit_valid,
    input  logic [VC_W-1:0]   credit_vc,
    output logic              busy,
    output logic              done,
    output logic              credit_err
);

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_PACKETS);

    inj_state_e state;
    inj_state_e state_next;

    // Table has no reset so its contents survive an aborting rst.
    pkt_entry_t table_mem [MAX_PACKETS];
    pkt_entry_t cur_pkt;

    logic [IDX_W:0]    num_pkts;
    logic [IDX_W:0]    ptr;
    logic [LEN_W-1:0]  flit_cnt;

    logic [VC_W-1:0]   cur_vc;
    logic [DEST_W-1:0] cur_dest;
    logic [LEN_W-1:0]  cur_len;
    logic              last_flit;
    logic              can_send;

    logic [NUM_VCS-1:0]   credit_nz;
    logic [NUM_VCS-1:0]   credit_ovf;
    // Padded to the full VC index range so any cur_vc indexes safely.
    logic [2**VC_W-1:0]   credit_nz_ext;

    logic unused_entry_bits;

    assign cur_vc    = cur_pkt.vc[VC_W-1:0];
    assign cur_dest  = cur_pkt.dest[DEST_W-1:0];
    assign cur_len   = cur_pkt.len[LEN_W-1:0];
    assign last_flit = (flit_cnt == cur_len - 1'b1);
    assign can_send  = (state == ST_SEND) && credit_nz_ext[cur_vc];

    assign unused_entry_bits = ^{cur_pkt.dest >> DEST_W, cur_pkt.vc >> VC_W, cur_pkt.len >> LEN_W};

    always_comb begin
        credit_nz_ext = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            credit_nz_ext[i] = credit_nz[i];
        end
    end

    for (genvar i = 0; i < NUM_VCS; i++) begin : g_vc
        vc_credit_counter #(
            .VCS_SIZE (VCS_SIZE)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .send     (can_send && (cur_vc == VC_W'(i))),
            .ret      (credit_valid && (credit_vc == VC_W'(i))),
            .nonzero  (credit_nz[i]),
            .overflow (credit_ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (cfg_num_packets == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (can_send && last_flit) begin
                    state_next = (ptr + 1'b1 == num_pkts) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (cfg_we && ((state == ST_IDLE) || (state == ST_DONE))) begin
            table_mem[cfg_idx] <= '{
                dest: ENTRY_DEST_W'(cfg_dest),
                vc:   ENTRY_VC_W'(cfg_vc),
                len:  (cfg_len == '0) ? ENTRY_LEN_W'(1) : ENTRY_LEN_W'(cfg_len)
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_pkts   <= '0;
            ptr        <= '0;
            flit_cnt   <= '0;
            cur_pkt    <= '0;
            flit_valid <= 1'b0;
            flit_type  <= 2'b00;
            flit_vc    <= '0;
            flit_dest  <= '0;
            flit_seq   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            busy       <= (state_next == ST_LOAD) || (state_next == ST_SEND);
            done       <= (state_next == ST_DONE);
            credit_err <= credit_err | (|credit_ovf);
            flit_valid <= can_send;

            if ((state == ST_IDLE) && start) begin
                // Counts beyond the table depth are clamped to the table size.
                num_pkts <= (cfg_num_packets > MAX_CNT) ? MAX_CNT : cfg_num_packets;
                ptr      <= '0;
            end

            if (state == ST_LOAD) begin
                cur_pkt  <= table_mem[ptr[IDX_W-1:0]];
                flit_cnt <= '0;
            end

            if (can_send) begin
                flit_type <= flit_type_for(flit_cnt == '0, last_flit);
                flit_vc   <= cur_vc;
                flit_dest <= cur_dest;
                flit_seq  <= flit_cnt;
                flit_cnt  <= flit_cnt + 1'b1;
                if (last_flit) begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// tb/tb_packet_injector.sv - directed self-checking bench for packet_injector
module tb_packet_injector;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [5:0] cfg_idx;
    logic [3:0] cfg_dest;
    logic [0:0] cfg_vc;
    logic [7:0] cfg_len;
    logic [6:0] cfg_num_packets;
    logic       start;
    logic       flit_valid;
    logic [1:0] flit_type;
    logic [0:0] flit_vc;
    logic [3:0] flit_dest;
    logic [7:0] flit_seq;
    logic       credit_valid;
    logic [0:0] credit_vc;
    logic       busy;
    logic       done;
    logic       credit_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    packet_injector dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_idx         (cfg_idx),
        .cfg_dest        (cfg_dest),
        .cfg_vc          (cfg_vc),
        .cfg_len         (cfg_len),
        .cfg_num_packets (cfg_num_packets),
        .start           (start),
        .flit_valid      (flit_valid),
        .flit_type       (flit_type),
        .flit_vc         (flit_vc),
        .flit_dest       (flit_dest),
        .flit_seq        (flit_seq),
        .credit_valid    (credit_valid),
        .credit_vc       (credit_vc),
        .busy            (busy),
        .done            (done),
        .credit_err      (credit_err)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flit(input string tag, input logic [1:0] ty, input logic [7:0] seq,
                              input logic [3:0] dest, input logic vc);
        check({tag, "_valid"}, 32'(flit_valid), 32'd1);
        check({tag, "_type"},  32'(flit_type),  32'(ty));
        check({tag, "_seq"},   32'(flit_seq),   32'(seq));
        check({tag, "_dest"},  32'(flit_dest),  32'(dest));
        check({tag, "_vc"},    32'(flit_vc),    32'(vc));
    endtask

    task automatic write_entry(input logic [5:0] idx, input logic [3:0] dest,
                               input logic vc, input logic [7:0] len);
        cfg_we = 1'b1; cfg_idx = idx; cfg_dest = dest; cfg_vc = vc; cfg_len = len;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic kick(input logic [6:0] n);
        cfg_num_packets = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_dest = '0; cfg_vc = '0; cfg_len = '0;
        cfg_num_packets = '0; start = 1'b0; credit_valid = 1'b0; credit_vc = '0;
        @(negedge clk);
        step();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(flit_valid), 32'd0);
        check("rst_type",  32'(flit_type), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(credit_err), 32'd0);
        check("rst_cred0", 32'(dut.g_vc[0].u_cnt.count), 32'd4);
        check("rst_cred1", 32'(dut.g_vc[1].u_cnt.count), 32'd4);

        // Single packet dest=5 vc=1 len=3
        write_entry(6'd0, 4'd5, 1'b1, 8'd3);
        kick(7'd1);
        check("sp_load_valid", 32'(flit_valid), 32'd0);
        check("sp_load_busy",  32'(busy), 32'd1);
        step();
        check("sp_send_valid", 32'(flit_valid), 32'd0);
        step();
        check_flit("sp_f0", 2'b01, 8'd0, 4'd5, 1'b1);
        step();
        check_flit("sp_f1", 2'b00, 8'd1, 4'd5, 1'b1);
        step();
        check_flit("sp_f2", 2'b10, 8'd2, 4'd5, 1'b1);
        check("sp_done", 32'(done), 32'd1);
        check("sp_busy", 32'(busy), 32'd0);
        check("sp_cred1", 32'(dut.g_vc[1].u_cnt.count), 32'd1);
        step();
        check("sp_idle_valid", 32'(flit_valid), 32'd0);
        check("sp_hold_seq",   32'(flit_seq), 32'd2);
        check("sp_hold_type",  32'(flit_type), 32'd2);
        credit_valid = 1'b1; credit_vc = 1'b1;
        step(); step(); step();
        credit_valid = 1'b0;
        check("sp_cred_back", 32'(dut.g_vc[1].u_cnt.count), 32'd4);
        check("sp_done_held", 32'(done), 32'd1);

        // len=1 and len=0 packets
        do_reset();
        write_entry(6'd0, 4'd2, 1'b0, 8'd1);
        write_entry(6'd1, 4'd7, 1'b1, 8'd0);
        kick(7'd2);
        step(); step();
        check_flit("ht_a", 2'b11, 8'd0, 4'd2, 1'b0);
        check("ht_a_done", 32'(done), 32'd0);
        step();
        check("ht_gap", 32'(flit_valid), 32'd0);
        step();
        check_flit("ht_b", 2'b11, 8'd0, 4'd7, 1'b1);
        check("ht_b_done", 32'(done), 32'd1);
        step();
        check("ht_after", 32'(flit_valid), 32'd0);

        // Credit stall: len=6 on vc0, four credits
        do_reset();
        write_entry(6'd0, 4'd9, 1'b0, 8'd6);
        kick(7'd1);
        step(); step();
        check_flit("cs_f0", 2'b01, 8'd0, 4'd9, 1'b0);
        step(); step(); step();
        check_flit("cs_f3", 2'b00, 8'd3, 4'd9, 1'b0);
        step();
        check("cs_stall", 32'(flit_valid), 32'd0);
        check("cs_cred0", 32'(dut.g_vc[0].u_cnt.count), 32'd0);
        step();
        check("cs_stall2", 32'(flit_valid), 32'd0);
        credit_valid = 1'b1; credit_vc = 1'b0;
        step();
        credit_valid = 1'b0;
        check("cs_ret_cycle", 32'(flit_valid), 32'd0);
        step();
        check_flit("cs_f4", 2'b00, 8'd4, 4'd9, 1'b0);
        step();
        check("cs_one_only", 32'(flit_valid), 32'd0);
        check("cs_busy", 32'(busy), 32'd1);

        // Same-cycle send and return at count 2; overflow on idle vc1
        do_reset();
        write_entry(6'd0, 4'd1, 1'b0, 8'd6);
        kick(7'd1);
        step(); step(); step();
        check("sc_pre_cred", 32'(dut.g_vc[0].u_cnt.count), 32'd2);
        credit_valid = 1'b1; credit_vc = 1'b0;
        step();
        credit_valid = 1'b0;
        check_flit("sc_f2", 2'b00, 8'd2, 4'd1, 1'b0);
        check("sc_cred_same", 32'(dut.g_vc[0].u_cnt.count), 32'd2);
        check("sc_err_pre", 32'(credit_err), 32'd0);
        credit_valid = 1'b1; credit_vc = 1'b1;
        step();
        credit_valid = 1'b0;
        check("ov_err", 32'(credit_err), 32'd1);
        check("ov_cred1", 32'(dut.g_vc[1].u_cnt.count), 32'd4);
        step();
        check("ov_sticky", 32'(credit_err), 32'd1);

        // Zero-packet start
        do_reset();
        check("z_err_cleared", 32'(credit_err), 32'd0);
        kick(7'd0);
        check("z_done", 32'(done), 32'd1);
        check("z_valid", 32'(flit_valid), 32'd0);
        check("z_busy", 32'(busy), 32'd0);
        step();
        check("z_done_held", 32'(done), 32'd1);

        // Reset mid-packet, table kept, write during SEND ignored
        do_reset();
        write_entry(6'd0, 4'd3, 1'b1, 8'd4);
        kick(7'd1);
        step(); step(); step();
        check_flit("ab_f1", 2'b00, 8'd1, 4'd3, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ab_valid", 32'(flit_valid), 32'd0);
        check("ab_seq", 32'(flit_seq), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_cred0", 32'(dut.g_vc[0].u_cnt.count), 32'd4);
        check("ab_cred1", 32'(dut.g_vc[1].u_cnt.count), 32'd4);
        kick(7'd1);
        step();
        cfg_we = 1'b1; cfg_idx = 6'd0; cfg_dest = 4'd12; cfg_vc = 1'b0; cfg_len = 8'd2;
        step();
        cfg_we = 1'b0;
        check_flit("kp_f0", 2'b01, 8'd0, 4'd3, 1'b1);
        step(); step(); step();
        check_flit("kp_f3", 2'b10, 8'd3, 4'd3, 1'b1);
        check("kp_done", 32'(done), 32'd1);
        do_reset();
        kick(7'd1);
        step(); step();
        check_flit("we_ign", 2'b01, 8'd0, 4'd3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_injector.md
PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, meaning the number of virtual channels on the local injection port.
REQ-002 SHALL have parameter VCS_SIZE, default 4, meaning the per-VC buffer depth in flits, which is also the initial credit count.
REQ-003 SHALL have parameter MAX_PACKETS, default 64, meaning the packet table depth.
REQ-004 SHALL have parameter NUM_OF_ROUTERS, default 16, meaning the node count; DEST_W = clog2(NUM_OF_ROUTERS).
REQ-005 SHALL have parameter LEN_W, default 8, meaning the width of the flits-per-packet field.
REQ-006 SHALL have ports, one per line:
  clk  in  1  single clock, rising edge; reset is synchronous and active-high
  rst  in  1  synchronous active-high reset
  cfg_we  in  1  write packet table entry
  cfg_idx  in  clog2(MAX_PACKETS)  entry index
  cfg_dest  in  DEST_W  destination node
  cfg_vc  in  clog2(NUM_VCS)  VC for packet
  cfg_len  in  LEN_W  flits in packet
  cfg_num_packets  in  clog2(MAX_PACKETS)+1  valid entries; sampled on start
  start  in  1  begin injection (level; acted on in IDLE)
  flit_valid  out  1  flit presented this cycle
  flit_type  out  2  01 head, 00 body, 10 tail, 11 head-tail
  flit_vc  out  clog2(NUM_VCS)  VC of flit
  flit_dest  out  DEST_W  destination
  flit_seq  out  LEN_W  flit index within packet, 0-based
  credit_valid  in  1  one credit returned
  credit_vc  in  clog2(NUM_VCS)  VC of returned credit
  busy  out  1  not IDLE and not DONE
  done  out  1  all packets injected; held until rst
  credit_err  out  1  sticky; credit return above VCS_SIZE

Function
REQ-007 SHALL implement FSM IDLE -> LOAD -> SEND -> (LOAD or DONE); DONE is terminal until rst.
REQ-008 In IDLE, start=1 SHALL latch cfg_num_packets, clear the packet pointer and go to LOAD; if the latched count is 0, go directly to DONE.
REQ-009 LOAD SHALL take exactly one cycle: read table[ptr] into the current-packet registers, clear the flit counter and enter SEND; flit_valid=0 in LOAD.
REQ-010 cfg_len=0 SHALL be treated as 1.
REQ-011 In SEND, flit_valid SHALL be 1 only when credit[cur_vc] > 0; a flit is consumed in every cycle flit_valid=1 (no ready; credit is the flow control).
REQ-012 flit_type SHALL be 11 when len=1; otherwise 01 for seq 0, 10 for seq len-1, and 00 between.
REQ-013 After the last flit, SHALL increment ptr; go to DONE if ptr reaches the latched count, else go to LOAD.
REQ-014 Per-VC credit counters SHALL reset to VCS_SIZE, decrement on a sent flit and increment on credit_valid; a same-VC send and return in the same cycle SHALL leave the count unchanged.
REQ-015 A credit return at count VCS_SIZE (with no simultaneous same-VC send) SHALL saturate the counter and set credit_err.
REQ-016 cfg_we SHALL be honoured only in IDLE and DONE; writes in other states SHALL be ignored.
REQ-017 Outputs SHALL be registered; flit outputs SHALL hold their last values when flit_valid=0.

Reset
REQ-018 rst SHALL force IDLE, ptr=0, all credits=VCS_SIZE, flit_valid=0, flit_type/vc/dest/seq=0, busy=0, done=0, credit_err=0.
REQ-019 rst asserted mid-packet SHALL abort immediately with no partial tail; table contents SHALL be preserved.

Structure
REQ-020 The flit type encodings, the state enum and the packet-entry fields SHALL live in a shared noc_pkg package.
REQ-021 Per-VC credit tracking SHALL be the sub-module vc_credit_counter, instantiated NUM_VCS times.

Verification
REQ-022 Single packet: dest=5, vc=1, len=3; start -> types 01,00,10 with seq 0,1,2 on 3 consecutive cycles starting 2 cycles after start; done follows.
REQ-023 Credit stall: VCS_SIZE=4, len=6, no credits returned -> 4 flits, then flit_valid=0; one credit -> exactly one more flit.
REQ-024 len=1 and len=0 packets -> one flit each with type 11.
REQ-025 Same-cycle send and credit on VC0 at count 2 -> count stays 2; a return at count 4 with no send -> credit_err=1, count stays 4.
REQ-026 cfg_num_packets=0, start -> DONE next cycle with no flit_valid; rst during seq 1 of len 4 -> flit_valid=0 and all credits=VCS_SIZE the next cycle.
